// File: rtl/nibble_write_sched.sv
// nibble_write_sched
//   Round-robin scheduler that shares one 4-bit register-write bus among
//   NUM_REQ requesters. A granted request writes one byte into a lo/hi pair
//   of 4-bit enable-gated registers: the low nibble in the first cycle and
//   the high nibble in the second. All outputs are registered and depend only
//   on registered state, so there is no combinational path from req to any
//   output.
//
// Ports
//   clk       clock, all state updates on posedge
//   reset     synchronous, active-high; returns the block to IDLE, clears
//             the round-robin pointer, the grant index and the latched byte
//   req       req[i]=1: requester i wants a byte write
//   req_addr  byte-register address, slice i belongs to requester i
//   req_data  byte to write, slice i belongs to requester i
//   ack       one-cycle completion pulse to the granted requester
//   nib_data  shared 4-bit data bus into the register bank
//   nib_en    one-hot write enables; bit 2a = lo nibble of reg a, 2a+1 = hi
//   busy      1 while a write is in progress (state != IDLE)
//
// Handshake: a requester raises req and holds it (addr/data may still change)
//   until it samples ack=1, then drops it. addr/data are captured only at the
//   grant edge. Dropping req after the grant does not abort the write. A req
//   still high in the IDLE cycle after its ack is treated as a new request.

module nibble_write_sched #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [3:0]                 nib_data,
  output logic [2*NUM_REGS-1:0]      nib_en,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t                  state_q,    state_d;
  logic [IDX_W-1:0]        rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]        gnt_idx_q,  gnt_idx_d;
  logic [ADDR_W-1:0]       addr_q,     addr_d;
  logic [7:0]              data_q,     data_d;
  logic [NUM_REQ-1:0]      ack_q,      ack_d;
  logic [3:0]              nib_data_q, nib_data_d;
  logic [2*NUM_REGS-1:0]   nib_en_q,   nib_en_d;

  logic                    found;
  logic [IDX_W:0]          cand_sum;
  logic [IDX_W-1:0]        cand;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    found     = 1'b0;
    cand_sum  = '0;
    cand      = '0;

    case (state_q)
      IDLE: begin
        // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first set req wins.
        // The inner loop keeps every slice select at a constant index.
        for (int off = 0; off < NUM_REQ; off++) begin
          cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
          if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
            cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
          end
          cand = cand_sum[IDX_W-1:0];
          for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && (cand == IDX_W'(j)) && req[j]) begin
              found     = 1'b1;
              gnt_idx_d = IDX_W'(j);
              addr_d    = req_addr[j*ADDR_W +: ADDR_W];
              data_d    = req_data[j*8 +: 8];
              state_d   = WR_LO;
            end
          end
        end
      end
      WR_LO: state_d = WR_HI;
      WR_HI: begin
        rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so that, once registered, they
    // line up with the state they describe. Addresses with no matching
    // register leave every enable low while the write still runs its course.
    ack_d      = '0;
    nib_en_d   = '0;
    nib_data_d = '0;
    if (state_d == WR_LO) begin
      nib_data_d = data_d[3:0];
      for (int r = 0; r < NUM_REGS; r++) begin
        if (addr_d == ADDR_W'(r)) nib_en_d[2*r] = 1'b1;
      end
    end else if (state_d == WR_HI) begin
      nib_data_d = data_q[7:4];
      for (int r = 0; r < NUM_REGS; r++) begin
        if (addr_q == ADDR_W'(r)) nib_en_d[2*r+1] = 1'b1;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (gnt_idx_q == IDX_W'(j)) ack_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      nib_data_q <= '0;
      nib_en_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      nib_data_q <= nib_data_d;
      nib_en_q   <= nib_en_d;
    end
  end

  assign ack      = ack_q;
  assign nib_data = nib_data_q;
  assign nib_en   = nib_en_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_write_sched.sv
// Testbench for nibble_write_sched: a reference model predicts every busy
// cycle's {ack, nib_en, nib_data}; a monitor compares at each negedge.
// A second instance with NUM_REGS=3 exercises the out-of-range address case.

module tb_nibble_write_sched;

  localparam int NR    = 4;
  localparam int NG    = 4;
  localparam int AW    = 2;
  localparam int EW    = NR + 2*NG + 4;
  localparam int BOUND = 3*NR + 3;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*8-1:0]   req_data;
  logic [NR-1:0]     ack;
  logic [3:0]        nib_data;
  logic [2*NG-1:0]   nib_en;
  logic              busy;

  logic [NR-1:0]     r3_req;
  logic [NR*AW-1:0]  r3_addr;
  logic [NR*8-1:0]   r3_data;
  logic [NR-1:0]     r3_ack;
  logic [3:0]        r3_nib_data;
  logic [5:0]        r3_nib_en;
  logic              r3_busy;

  nibble_write_sched #(.NUM_REQ(NR), .NUM_REGS(NG), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .nib_data(nib_data), .nib_en(nib_en), .busy(busy)
  );

  nibble_write_sched #(.NUM_REQ(NR), .NUM_REGS(3), .ADDR_W(AW)) u_dut3 (
    .clk(clk), .reset(reset), .req(r3_req), .req_addr(r3_addr), .req_data(r3_data),
    .ack(r3_ack), .nib_data(r3_nib_data), .nib_en(r3_nib_en), .busy(r3_busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            ack_log[$];
  int            n_vec;
  int            n_err;
  bit            mon_en;
  int            wait_cnt[NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (((v >> i) & 1) != 0) return i;
    return -1;
  endfunction

  // Reference model: a byte write is one grant followed by two bus cycles;
  // the pointer moves past the winner once its second cycle completes.
  task automatic model_loop();
    int m_rr, m_left, m_g, a;
    logic [7:0]      d;
    logic [2*NG-1:0] en;
    m_rr = 0; m_left = 0; m_g = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_rr = 0; m_left = 0;
        exp_q.delete();
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_rr = (m_g + 1) % NR;
      end else if (req != 0) begin
        for (int k = 0; k < NR; k++) begin
          if (((req >> ((m_rr + k) % NR)) & 1) != 0) begin
            m_g = (m_rr + k) % NR;
            break;
          end
        end
        a  = int'(AW'(req_addr >> (AW*m_g)));
        d  = 8'(req_data >> (8*m_g));
        en = (a < NG) ? ((2*NG)'(1) << (2*a)) : '0;
        exp_q.push_back({NR'(0), en, d[3:0]});
        en = (a < NG) ? ((2*NG)'(1) << (2*a+1)) : '0;
        exp_q.push_back({NR'(1) << m_g, en, d[7:4]});
        m_left = 2;
      end
    end
  endtask

  task automatic monitor_loop();
    logic [EW-1:0] got, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        got = {ack, nib_en, nib_data};
        if (busy) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: got busy output 0x%0h, want no write in flight", got);
          end else begin
            e = exp_q.pop_front();
            chk("sb_busy_cycle", 32'(got), 32'(e));
          end
        end else begin
          chk("sb_idle_cycle", 32'(got), 32'h0);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input int a, input logic [7:0] d);
    req_addr = (req_addr & ~((NR*AW)'((1 << AW) - 1) << (AW*i))) | ((NR*AW)'(a) << (AW*i));
    req_data = (req_data & ~((NR*8)'(8'hFF) << (8*i))) | ((NR*8)'(d) << (8*i));
  endtask

  // Requesters follow the handshake: hold req until ack is seen, then drop.
  // With rnd set, idle requesters randomly raise new requests and held ones
  // randomly change addr/data (which must be ignored after the grant).
  task automatic run_hs(input int cycles, input bit rnd);
    logic [NR-1:0] a_v;
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      a_v = ack;
      for (int i = 0; i < NR; i++) begin
        if (((req >> i) & 1) != 0) wait_cnt[i]++;
        if (((a_v >> i) & 1) != 0) begin
          ack_log.push_back(i);
          chk("fair_wait_ok", (wait_cnt[i] <= BOUND) ? 1 : 0, 1);
        end
      end
      @(posedge clk);
      #1;
      req = req & ~a_v;
      if (rnd) begin
        for (int i = 0; i < NR; i++) begin
          if (((req >> i) & 1) != 0) begin
            if ($urandom_range(0, 4) == 0)
              set_slot(i, int'($urandom_range(0, NG-1)), 8'($urandom));
          end else if ((((a_v >> i) & 1) == 0) && ($urandom_range(0, 3) == 0)) begin
            set_slot(i, int'($urandom_range(0, NG-1)), 8'($urandom));
            req = req | (NR'(1) << i);
            wait_cnt[i] = 0;
          end
        end
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int cyc_log[$];
    n_vec = 0; n_err = 0; mon_en = 1'b0;
    reset = 1'b1; req = '0; req_addr = '0; req_data = '0;
    r3_req = '0; r3_addr = '0; r3_data = '0;
    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (3) step();
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_nib_en", nib_en, 0);
    chk("rst_nib_data", nib_data, 0);
    chk("rst_busy", busy, 0);

    // 1. single write of 0xA5 to register 2 from requester 0
    set_slot(0, 2, 8'hA5);
    req = 4'b0001;
    step();
    @(negedge clk);
    chk("t1_lo_en", nib_en, 8'h10);
    chk("t1_lo_data", nib_data, 4'h5);
    chk("t1_lo_ack", ack, 0);
    chk("t1_lo_busy", busy, 1);
    step();
    @(negedge clk);
    chk("t1_hi_en", nib_en, 8'h20);
    chk("t1_hi_data", nib_data, 4'hA);
    chk("t1_hi_ack", ack, 4'b0001);
    step();
    req = '0;
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);

    // 2. all four requesting continuously from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_slot(i, i, 8'($urandom));
    req = 4'b1111;
    ack_log.delete();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        ack_log.push_back(oh_idx(ack));
        cyc_log.push_back(c);
      end
      step();
    end
    req = '0;
    chk("t2_num_acks", ack_log.size(), 5);
    if (ack_log.size() == 5) begin
      chk("t2_order0", ack_log[0], 0);
      chk("t2_order1", ack_log[1], 1);
      chk("t2_order2", ack_log[2], 2);
      chk("t2_order3", ack_log[3], 3);
      chk("t2_order4", ack_log[4], 0);
      for (int k = 1; k < 5; k++) chk("t2_ack_spacing", cyc_log[k] - cyc_log[k-1], 3);
    end
    repeat (2) step();

    // 3. rr_ptr=2 with requesters 1 and 3 pending: 3 first; data change after grant ignored
    set_slot(1, 0, 8'($urandom));
    req = 4'b0010;
    run_hs(4, 1'b0);
    ack_log.delete();
    set_slot(1, 1, 8'h11);
    set_slot(3, 2, 8'h33);
    req = 4'b1010;
    step();
    set_slot(3, 3, 8'hFF);
    run_hs(7, 1'b0);
    chk("t3_num_acks", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      chk("t3_first", ack_log[0], 3);
      chk("t3_second", ack_log[1], 1);
    end

    // 4. reset while in WR_LO aborts the write and clears rr_ptr
    set_slot(2, 1, 8'h5A);
    req = 4'b0100;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    chk("t4_nib_en", nib_en, 0);
    chk("t4_ack", ack, 0);
    chk("t4_busy", busy, 0);
    ack_log.delete();
    set_slot(1, 0, 8'h12);
    set_slot(3, 3, 8'h34);
    req = 4'b1010;
    run_hs(8, 1'b0);
    chk("t4_num_acks", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      chk("t4_first", ack_log[0], 1);
      chk("t4_second", ack_log[1], 3);
    end

    // 6. req dropped during WR_LO: write completes, then stays IDLE
    set_slot(0, 3, 8'hC3);
    req = 4'b0001;
    step();
    req = '0;
    @(negedge clk);
    chk("t6_lo_busy", busy, 1);
    chk("t6_lo_en", nib_en, 8'h40);
    chk("t6_lo_data", nib_data, 4'h3);
    step();
    @(negedge clk);
    chk("t6_hi_ack", ack, 4'b0001);
    chk("t6_hi_en", nib_en, 8'h80);
    chk("t6_hi_data", nib_data, 4'hC);
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      chk("t6_stays_idle", busy, 0);
    end

    // 5. NUM_REGS=3 instance: addr 3 writes nothing but still acks
    r3_addr = 8'h03;
    r3_data = 32'h0000_005C;
    r3_req  = 4'b0001;
    step();
    @(negedge clk);
    chk("t5_lo_en", r3_nib_en, 0);
    chk("t5_lo_busy", r3_busy, 1);
    chk("t5_lo_ack", r3_ack, 0);
    step();
    @(negedge clk);
    chk("t5_hi_en", r3_nib_en, 0);
    chk("t5_hi_ack", r3_ack, 4'b0001);
    step();
    r3_req = '0;
    @(negedge clk);
    chk("t5_idle_busy", r3_busy, 0);
    r3_addr = 8'h02;
    r3_data = 32'h0000_0096;
    r3_req  = 4'b0001;
    step();
    r3_req = '0;
    @(negedge clk);
    chk("t5_valid_lo_en", r3_nib_en, 6'h10);
    chk("t5_valid_lo_data", r3_nib_data, 4'h6);
    step();
    @(negedge clk);
    chk("t5_valid_hi_en", r3_nib_en, 6'h20);
    chk("t5_valid_hi_data", r3_nib_data, 4'h9);
    chk("t5_valid_hi_ack", r3_ack, 4'b0001);

    // randomized traffic against the model
    run_hs(900, 1'b1);
    for (int i = 0; i < NR; i++) begin
      if (((req >> i) & 1) != 0) chk("pending_wait_ok", (wait_cnt[i] <= BOUND) ? 1 : 0, 1);
    end
    req = '0;
    run_hs(8, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
